blink_mask_gen: RTL

- Parametrised successor to the single-digit half-second blinker.
- Takes N display channels (W-bit segment patterns each) and blinks one selected channel while the clock is being set. All other channels pass through unchanged.
- Adds a configurable period and duty, a fast-blink mode, and blink restart on selection change.
- Adds a hold-off window after a user press, so the edited digit stays visible while it is being changed.
- Sits between the time/alarm digit mux and the 7-segment drivers.

---
 rtl/clk_disp_pkg.sv | 8 +
 rtl/blink_timer.sv | 25 ++
 rtl/blink_mask_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/clk_disp_pkg.sv
// clk_disp_pkg: shared blinker states and 50 MHz board defaults.
package clk_disp_pkg;
  typedef enum logic [2:0] {PASS, SHOW, DARK, HOLD, HOFF} state_t;
  localparam logic [7:0] BLANK_SEG = 8'hFF;
  localparam int unsigned PERIOD_50M = 50_000_000;
  localparam int unsigned ON_50M = 10_000_000;
  localparam int unsigned HOLD_50M = 25_000_000;
endpackage

// File: rtl/blink_timer.sv
// blink_timer: period counter with slow/fast limits; reports the phase of the next count and the wrap point.
module blink_timer #(
  parameter int unsigned PERIOD = 50_000_000,
  parameter int unsigned ON_CYC = 10_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic fast,
  input  logic run,
  output logic on_phase,
  output logic wrap
);
  logic [31:0] cnt, p, on, step;
  always_comb begin
    p = fast ? 32'(PERIOD / 2) : 32'(PERIOD);
    on = fast ? 32'(ON_CYC / 2) : 32'(ON_CYC);
    wrap = cnt >= p - 32'd1;
    step = wrap ? 32'd0 : cnt + 32'd1;
    on_phase = step < on;
  end
  // >= rather than == so a shortened fast period still wraps cleanly
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= run ? step : 32'd0;
endmodule

// File: rtl/blink_mask_gen.sv
// blink_mask_gen: blanks the selected display channel on a configurable blink cadence while editing.
module blink_mask_gen
  import clk_disp_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter int SEL_W = 2,
  parameter int unsigned PERIOD = PERIOD_50M,
  parameter int unsigned ON_CYC = ON_50M,
  parameter int unsigned HOLD_CYC = HOLD_50M,
  parameter logic [W-1:0] BLANK = {W{1'b1}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_CH*W-1:0] digits_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              edit_en,
  input  logic              hold,
  input  logic              fast,
  output logic [N_CH*W-1:0] digits_out,
  output logic              dark
);
  state_t st, nst;
  logic [SEL_W-1:0] sel_q;
  logic [31:0] hoff, hoff_n;
  logic run, on_phase, wrap;
  logic [N_CH*W-1:0] masked;
  blink_timer #(.PERIOD(PERIOD), .ON_CYC(ON_CYC)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .fast(fast),
    .run(run),
    .on_phase(on_phase),
    .wrap(wrap)
  );
  // the timer only advances while blinking; every other path restarts it from zero
  always_comb begin
    nst = st;
    run = 1'b0;
    hoff_n = hoff;
    if (!edit_en || 32'(sel) >= N_CH) begin
      nst = PASS;
      hoff_n = '0;
    end else if (hold) nst = HOLD;
    else if (sel != sel_q) begin
      nst = SHOW;
      hoff_n = '0;
    end else begin
      case (st)
        PASS: nst = SHOW;
        SHOW: begin
          run = 1'b1;
          nst = on_phase ? SHOW : DARK;
        end
        DARK: begin
          run = 1'b1;
          nst = wrap ? SHOW : DARK;
        end
        HOLD: begin
          nst = HOFF;
          hoff_n = 32'(HOLD_CYC - 1);
        end
        HOFF: begin
          nst = hoff == '0 ? SHOW : HOFF;
          hoff_n = hoff == '0 ? '0 : hoff - 32'd1;
        end
        default: nst = PASS;
      endcase
    end
  end
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign masked[k*W +: W] = (nst == DARK && 32'(sel) == k) ? BLANK : digits_in[k*W +: W];
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st <= PASS;
      sel_q <= '0;
      hoff <= '0;
      digits_out <= {N_CH{BLANK}};
      dark <= 1'b0;
    end else begin
      st <= nst;
      sel_q <= sel;
      hoff <= hoff_n;
      digits_out <= masked;
      dark <= nst == DARK;
    end
endmodule
